// File: rtl/sp_ram_obi_arbiter.sv
// Round-robin arbiter sharing one single-port, byte-enabled RAM (1-cycle read latency)
// between an instruction-fetch OBI port and a data OBI port.
module sp_ram_obi_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter bit ERR_OOR    = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    output logic                  instr_err_o,

    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic [31:0]           data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic                  data_err_o,

    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    port_e       r_rr_last;
    logic        r_resp_vld;
    port_e       r_resp_port;
    logic        r_resp_we;
    logic        r_resp_err;

    logic        w_instr_win;
    logic        w_data_win;
    logic        w_grant;
    logic [31:0] w_addr;
    logic [31:0] w_upper;
    logic        w_oor;
    logic        w_ram_en;
    logic        w_rsp_live;
    logic        w_rsp_has_data;

    // Grants are held off during reset; on contention the port that did not win last goes.
    always_comb begin
        w_instr_win = rst_ni && instr_req_i && (!data_req_i || (r_rr_last == PORT_DATA));
        w_data_win  = rst_ni && data_req_i  && (!instr_req_i || (r_rr_last == PORT_INSTR));
        w_grant     = w_instr_win || w_data_win;
    end

    assign instr_gnt_o = w_instr_win;
    assign data_gnt_o  = w_data_win;

    always_comb begin
        w_addr  = w_data_win ? data_addr_i : instr_addr_i;
        w_upper = w_addr >> ADDR_WIDTH;
        w_oor   = ERR_OOR && (w_upper != 32'h0);
        w_ram_en = w_grant && !w_oor;
    end

    // RAM side is fully zeroed when not enabled so idle cycles never look like accesses.
    always_comb begin
        ram_en_o    = w_ram_en;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_wdata_o = 32'h0;
        if (w_ram_en) begin
            ram_addr_o = w_addr[ADDR_WIDTH-1:0];
            if (w_data_win) begin
                ram_we_o    = data_we_i;
                ram_be_o    = data_be_i;
                ram_wdata_o = data_wdata_i;
            end else begin
                ram_be_o    = 4'hF;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_last   <= PORT_DATA;
            r_resp_vld  <= 1'b0;
            r_resp_port <= PORT_INSTR;
            r_resp_we   <= 1'b0;
            r_resp_err  <= 1'b0;
        end else begin
            r_resp_vld <= w_grant;
            if (w_grant) begin
                r_rr_last   <= w_data_win ? PORT_DATA : PORT_INSTR;
                r_resp_port <= w_data_win ? PORT_DATA : PORT_INSTR;
                r_resp_we   <= w_data_win && data_we_i;
                r_resp_err  <= w_oor;
            end
        end
    end

    // Response outputs are masked by reset so a pending response is dropped immediately.
    always_comb begin
        w_rsp_live     = rst_ni && r_resp_vld;
        w_rsp_has_data = w_rsp_live && !r_resp_we && !r_resp_err;
    end

    always_comb begin
        instr_rvalid_o = w_rsp_live && (r_resp_port == PORT_INSTR);
        data_rvalid_o  = w_rsp_live && (r_resp_port == PORT_DATA);
        instr_err_o    = instr_rvalid_o && r_resp_err;
        data_err_o     = data_rvalid_o && r_resp_err;
        instr_rdata_o  = (w_rsp_has_data && (r_resp_port == PORT_INSTR)) ? ram_rdata_i : 32'h0;
        data_rdata_o   = (w_rsp_has_data && (r_resp_port == PORT_DATA))  ? ram_rdata_i : 32'h0;
    end

    a_one_grant: assert property (@(posedge clk_i) !(instr_gnt_o && data_gnt_o));
    a_one_rvalid: assert property (@(posedge clk_i) !(instr_rvalid_o && data_rvalid_o));

endmodule

// File: tb/tb_sp_ram_obi_arbiter.sv
// Directed self-checking bench for sp_ram_obi_arbiter with a behavioural 4 KiB RAM.
module tb_sp_ram_obi_arbiter;

    logic        clk;
    logic        rstN;
    logic        instrReq;
    logic        instrGnt;
    logic [31:0] instrAddr;
    logic        instrRvalid;
    logic [31:0] instrRdata;
    logic        instrErr;
    logic        dataReq;
    logic        dataGnt;
    logic [31:0] dataAddr;
    logic        dataWe;
    logic [3:0]  dataBe;
    logic [31:0] dataWdata;
    logic        dataRvalid;
    logic [31:0] dataRdata;
    logic        dataErr;
    logic        ramEn;
    logic [11:0] ramAddr;
    logic        ramWe;
    logic [3:0]  ramBe;
    logic [31:0] ramWdata;
    logic [31:0] ramRdata;

    int total;
    int bad;

    sp_ram_obi_arbiter #(.ADDR_WIDTH(12), .ERR_OOR(1'b1)) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .instr_req_i   (instrReq),
        .instr_gnt_o   (instrGnt),
        .instr_addr_i  (instrAddr),
        .instr_rvalid_o(instrRvalid),
        .instr_rdata_o (instrRdata),
        .instr_err_o   (instrErr),
        .data_req_i    (dataReq),
        .data_gnt_o    (dataGnt),
        .data_addr_i   (dataAddr),
        .data_we_i     (dataWe),
        .data_be_i     (dataBe),
        .data_wdata_i  (dataWdata),
        .data_rvalid_o (dataRvalid),
        .data_rdata_o  (dataRdata),
        .data_err_o    (dataErr),
        .ram_en_o      (ramEn),
        .ram_addr_o    (ramAddr),
        .ram_we_o      (ramWe),
        .ram_be_o      (ramBe),
        .ram_wdata_o   (ramWdata),
        .ram_rdata_i   (ramRdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: word i holds 0xA0000000|i, except two preloaded test words.
    initial begin
        logic [31:0] mem [0:1023];
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        mem[4] = 32'hDEAD_BEEF;
        mem[8] = 32'h1122_3344;
        ramRdata = 32'h0;
        forever begin
            @(posedge clk);
            if (ramEn) begin
                if (ramWe) begin
                    for (int b = 0; b < 4; b++)
                        if (ramBe[b]) mem[ramAddr[11:2]][b*8 +: 8] <= ramWdata[b*8 +: 8];
                end
                ramRdata <= mem[ramAddr[11:2]];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                                 input logic dReq, input logic dWe, input logic [3:0] dBe,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata);
        instrReq  = iReq;
        instrAddr = iAddr;
        dataReq   = dReq;
        dataWe    = dWe;
        dataBe    = dBe;
        dataAddr  = dAddr;
        dataWdata = dWdata;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstN  = 1'b0;
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);

        // Reset held with both requests up: nothing granted, no responses.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("rst_igNT", {31'b0, instrGnt}, 32'h0);
            checkOutput("rst_dgnt", {31'b0, dataGnt}, 32'h0);
            checkOutput("rst_rvalid", {30'b0, instrRvalid, dataRvalid}, 32'h0);
            checkOutput("rst_err", {30'b0, instrErr, dataErr}, 32'h0);
            checkOutput("rst_rdata", instrRdata | dataRdata, 32'h0);
            checkOutput("rst_ramen", {31'b0, ramEn}, 32'h0);
        end
        rstN = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1 checkOutput("idle_gnt", {30'b0, instrGnt, dataGnt}, 32'h0);

        // Solo fetch.
        @(negedge clk);
        checkOutput("idle_rvalid", {30'b0, instrRvalid, dataRvalid}, 32'h0);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("f_gnt", {30'b0, instrGnt, dataGnt}, 32'h2);
        checkOutput("f_ramen", {31'b0, ramEn}, 32'h1);
        checkOutput("f_ramaddr", {20'b0, ramAddr}, 32'h10);
        checkOutput("f_ramwe_be", {27'b0, ramWe, ramBe}, 32'h0F);
        @(negedge clk);
        checkOutput("f_rvalid", {30'b0, instrRvalid, dataRvalid}, 32'h2);
        checkOutput("f_rdata", instrRdata, 32'hDEAD_BEEF);
        checkOutput("f_err", {31'b0, instrErr}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000_AB00);

        // Byte write then immediate read of the same word.
        #1;
        checkOutput("w_gnt", {30'b0, instrGnt, dataGnt}, 32'h1);
        checkOutput("w_ramwe_be", {27'b0, ramWe, ramBe}, 32'h12);
        checkOutput("w_wdata", ramWdata, 32'h0000_AB00);
        @(negedge clk);
        checkOutput("w_rvalid", {30'b0, instrRvalid, dataRvalid}, 32'h1);
        checkOutput("w_rdata", dataRdata, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        #1 checkOutput("r_ramwe", {31'b0, ramWe}, 32'h0);
        @(negedge clk);
        checkOutput("r_rvalid", {31'b0, dataRvalid}, 32'h1);
        checkOutput("r_rdata", dataRdata, 32'h1122_AB44);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Contention: last winner was data, so instr goes first, then alternate.
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checkOutput($sformatf("c%0d_ivld", k-1), {31'b0, instrRvalid}, {31'b0, ((k-1) % 2) == 0});
                checkOutput($sformatf("c%0d_dvld", k-1), {31'b0, dataRvalid}, {31'b0, ((k-1) % 2) == 1});
                checkOutput($sformatf("c%0d_irdata", k-1), instrRdata, (((k-1) % 2) == 0) ? 32'hA000_0010 : 32'h0);
                checkOutput($sformatf("c%0d_drdata", k-1), dataRdata, (((k-1) % 2) == 1) ? 32'hA000_0020 : 32'h0);
            end
            if (k < 6) begin
                applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
                #1;
                checkOutput($sformatf("c%0d_gnt", k), {30'b0, instrGnt, dataGnt}, ((k % 2) == 0) ? 32'h2 : 32'h1);
            end else begin
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
        end

        // Top in-range word is accessed normally.
        applyStimulus(1'b1, 32'hFFC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1 checkOutput("top_ramen", {31'b0, ramEn}, 32'h1);
        @(negedge clk);
        checkOutput("top_rdata", instrRdata, 32'hA000_03FF);
        checkOutput("top_err", {31'b0, instrErr}, 32'h0);

        // Out of range data read: granted, RAM untouched, error response.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
        #1;
        checkOutput("oor_gnt", {31'b0, dataGnt}, 32'h1);
        checkOutput("oor_ramen", {31'b0, ramEn}, 32'h0);
        checkOutput("oor_rambe", {28'b0, ramBe}, 32'h0);
        @(negedge clk);
        checkOutput("oor_rvalid", {31'b0, dataRvalid}, 32'h1);
        checkOutput("oor_err", {31'b0, dataErr}, 32'h1);
        checkOutput("oor_rdata", dataRdata, 32'h0);

        // Reset mid-op: fetch granted, reset next cycle drops response and re-arms instr-first.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1 checkOutput("rm_gnt", {30'b0, instrGnt, dataGnt}, 32'h2);
        @(negedge clk);
        rstN = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("rm_rvalid", {30'b0, instrRvalid, dataRvalid}, 32'h0);
        checkOutput("rm_rdata", instrRdata, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        #1;
        checkOutput("rm_stale", {30'b0, instrRvalid, dataRvalid}, 32'h0);
        checkOutput("rm_rr", {30'b0, instrGnt, dataGnt}, 32'h2);
        @(negedge clk);
        checkOutput("rm_rvalid2", {30'b0, instrRvalid, dataRvalid}, 32'h2);
        checkOutput("rm_rdata2", instrRdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
